// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative unsigned shift-add multiply / restoring divide, one bit per cycle,
// with a start/busy/done handshake and a registered result.
module alu_muldiv_iter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] In_a,
  input  logic [WIDTH-1:0] In_b,
  input  logic [1:0]       Op,
  input  logic             Start,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [1:0]         r_op;
  logic               r_dz;
  logic               r_done;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_result;
  logic               w_acc;
  logic               w_fin;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH:0]     w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;
  logic [WIDTH-1:0]   w_res;
  assign w_acc  = (r_state == IDLE) && Start;
  assign w_fin  = (r_state == RUN) && (r_dz || r_cnt == CW'(WIDTH - 1));
  assign Busy   = (r_state == RUN);
  assign Done   = r_done;
  assign Result = r_result;
  always_comb begin
    w_state_nxt = r_state;
    if (w_acc) w_state_nxt = RUN;
    else if (w_fin) w_state_nxt = IDLE;
  end
  // Carry of the add lands in the extra bit and becomes the product MSB after the shift.
  always_comb begin
    w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_prod[0] ? r_b : {WIDTH{1'b0}}};
    w_prod_nxt = {w_sum, r_prod[WIDTH-1:1]};
    w_rem_sh   = (r_rem << 1) | {{WIDTH{1'b0}}, r_quo[WIDTH-1]};
    w_diff     = w_rem_sh - {1'b0, r_b};
    w_ge       = w_rem_sh >= {1'b0, r_b};
    w_rem_nxt  = w_ge ? w_diff : w_rem_sh;
    w_quo_nxt  = {r_quo[WIDTH-2:0], w_ge};
    w_res      = !r_op[1] ? (r_op[0] ? w_prod_nxt[2*WIDTH-1:WIDTH] : w_prod_nxt[WIDTH-1:0])
               : r_dz     ? (r_op[0] ? r_quo : {WIDTH{1'b1}})
               : (r_op[0] ? w_rem_nxt[WIDTH-1:0] : w_quo_nxt);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_b      <= '0;
      r_prod   <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_result <= '0;
    end else begin
      r_done <= w_fin;
      if (w_fin) r_result <= w_res;
      if (w_acc) begin
        r_op   <= Op;
        r_b    <= In_b;
        r_dz   <= Op[1] && (In_b == '0);
        r_prod <= {{WIDTH{1'b0}}, In_a};
        r_rem  <= '0;
        r_quo  <= In_a;
        r_cnt  <= '0;
      end else if (r_state == RUN) begin
        r_prod <= w_prod_nxt;
        r_rem  <= w_rem_nxt;
        r_quo  <= w_quo_nxt;
        r_cnt  <= w_fin ? '0 : r_cnt + CW'(1);
      end
    end
  end
endmodule

// File: doc/alu_muldiv_iter.md
# alu_muldiv_iter

Iterative unsigned multiply/divide unit sitting directly downstream of the ALU operand-B 2:1 select stage in the RISC-V execute path. It consumes the selected operand B plus operand A, runs a one-bit-per-cycle shift-add multiply or restoring divide, and returns a registered result with a start/busy/done handshake. The pipeline stalls on `busy`. The datapath width matches the current narrow execute path, which is 6 bits, and is parameterised for the later move to 32 bits.

## Interface
- `WIDTH`, default 6: operand and result width in bits; must be ≥ 2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `In_a` input WIDTH: operand A (multiplicand / dividend).
- `In_b` input WIDTH: operand B, taken from the operand-select stage (multiplier / divisor).
- `Op` input 2: operation select.
  - 00 = MUL (low half of product)
  - 01 = MULHU (high half of product)
  - 10 = DIVU (quotient)
  - 11 = REMU (remainder)
- `Start` input 1: request pulse. Operands and `Op` are sampled on the edge where `Start`=1 and `Busy`=0.
- `Busy` output 1: operation in progress.
- `Done` output 1: one-cycle pulse; `Result` is valid from this cycle on.
- `Result` output WIDTH: registered result, held until the next accepted `Start`.

## Operation
- **FSM states:**
  - IDLE: `Busy`=0.
  - RUN: `Busy`=1, iteration counter `cnt` counts 0..WIDTH-1.
- **IDLE → RUN** on accepted `Start`.
  - Latch A, B and `Op`; clear the working registers; set `cnt`=0.
- **Multiply (Op[1]=0):**
  - 2·WIDTH product register, initialised {0, A}.
  - Each iteration: if product LSB is 1, add B into the upper WIDTH+1 bits; then shift the whole product right by 1 (carry shifts into the MSB).
  - After WIDTH iterations:
    - MUL = product[WIDTH-1:0]
    - MULHU = product[2·WIDTH-1:WIDTH]
- **Divide (Op[1]=1), restoring:**
  - Registers: remainder R (WIDTH+1 bits, initialised 0), quotient Q (initialised A).
  - Each iteration: shift {R,Q} left by 1, then trial-subtract B from R.
    - If the result is non-negative, keep it and set Q[0]=1.
    - Otherwise restore R and set Q[0]=0.
  - DIVU = Q; REMU = R[WIDTH-1:0].
- **Divide by zero (B=0 at acceptance with Op[1]=1):**
  - Short-circuit with no iteration.
  - DIVU = all ones; REMU = A (RISC-V semantics).
- **Multiply by zero:** not short-circuited; runs the full WIDTH iterations.
- **RUN → IDLE** on the edge that completes iteration WIDTH-1 (or on the short-circuit edge).
  - Same edge: load `Result`, assert `Done`, clear `Busy`.
- **`Start` while `Busy`=1:** ignored; no latching, no effect on the running operation.
- **`Start` in the `Done` cycle:** FSM is already in IDLE, so the request is accepted. `Done` drops on the next edge and `Result` keeps its value until the new operation completes.
- **Operand changes after acceptance:** no effect; only latched copies are used.
- **Arithmetic:** all unsigned. No overflow is possible in the product register. The addition carry is held in the extra upper bit.

## Timing
- **Reset (asynchronous, any time, including mid-RUN):**
  - State=IDLE, `Busy`=0, `Done`=0, `Result`=0, `cnt`=0, working registers 0.
  - The in-flight operation is discarded; no `Done` follows.
- **Normal latency:** `Start` sampled at edge k.
  - `Busy`=1 after edge k.
  - Iterations occur on edges k+1..k+WIDTH.
  - `Done`=1 and `Result` valid after edge k+WIDTH; `Busy`=0 at the same time.
  - With WIDTH=6: `Done` is seen 6 cycles after the accepting edge.
- **Divide-by-zero latency:** `Done` after edge k+1.
- **`Done` pulse width:** exactly one cycle.
- **Back-to-back throughput:** one operation per WIDTH+1 cycles, with `Start` asserted in each `Done` cycle.
- **Output timing:** all outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Reset values:** assert `rst` asynchronously between clock edges → `Busy`=0, `Done`=0 and `Result`=0 immediately, without waiting for a clock edge.
- **Multiply, WIDTH=6:**
  - A=7, B=9, Op=00 → after 6 cycles `Done` pulses once, `Result`=63.
  - Same operands, Op=01 → `Result`=0.
- **Full-scale multiply:** A=63, B=63 → MUL `Result`=1; MULHU `Result`=62 (product 3969).
- **Divide:**
  - A=45, B=7, Op=10 → `Result`=6.
  - Same operands, Op=11 → `Result`=3.
  - Divide by zero, A=20, B=0: DIVU → `Result`=63 and REMU → `Result`=20, each with `Done` one cycle after acceptance.
- **Handshake:**
  - `Start` with A=5, B=3 MUL, then pulse `Start` again with different operands at cycle 3 while busy → ignored; `Result`=15.
  - `Start` asserted in the `Done` cycle → new operation accepted; `Busy` stays high after that edge (`Done` deasserts).
- **Reset mid-operation:** `rst` during cycle 3 of a DIVU → outputs clear, no `Done` appears. A following `Start` with A=12, B=4, Op=10 → `Result`=3 with normal latency.
